ram_dp_responder: RTL

- Synthesizable dual-port synchronous RAM that responds to the write/read OVC traffic on the RAM interface.
- It is the DUV end of that interface.
- Accepts one write and one read per clock, with 1-cycle registered read latency.
- A post-reset clear sequence zeroes every word before traffic is accepted.
- Sits behind the interface's DUV modport; the extra status outputs feed the scoreboard and assertions.

---
 rtl/ram_dp_responder_pkg.sv | 15 +
 rtl/ram_dp_responder_if.sv | 26 ++
 rtl/ram_dp_responder_array.sv | 41 ++++
 rtl/ram_dp_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ram_dp_responder_pkg.sv
// ram_pkg: shared constants and types for the dual-port RAM responder.
package ram_pkg;

    localparam int RAM_WIDTH = 64;
    localparam int ADDR_SIZE = 12;

    typedef logic [RAM_WIDTH-1:0] ram_data_t;
    typedef logic [ADDR_SIZE-1:0] ram_addr_t;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_dp_responder_if.sv
// ram_dp_responder_if: write/read traffic plus status flags between the
// traffic generator (master) and the RAM responder (slave).
interface ram_dp_responder_if #(
    parameter int RAM_WIDTH = ram_pkg::RAM_WIDTH,
    parameter int ADDR_SIZE = ram_pkg::ADDR_SIZE
);
    logic [RAM_WIDTH-1:0] data_in;
    logic [ADDR_SIZE-1:0] wr_address;
    logic                 write;
    logic [ADDR_SIZE-1:0] rd_address;
    logic                 read;
    logic [RAM_WIDTH-1:0] data_out;
    logic                 rd_valid;
    logic                 busy;
    logic                 drop_err;

    modport master (
        output data_in, wr_address, write, rd_address, read,
        input  data_out, rd_valid, busy, drop_err
    );

    modport slave (
        input  data_in, wr_address, write, rd_address, read,
        output data_out, rd_valid, busy, drop_err
    );
endinterface

// File: rtl/ram_dp_responder_array.sv
// ram_dp_array: plain storage array, one write port and one registered read
// port. The storage itself is never reset; only the read register is. When no
// read is requested the read register returns zero.
module ram_dp_array #(
    parameter int RAM_WIDTH = ram_pkg::RAM_WIDTH,
    parameter int ADDR_SIZE = ram_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [ADDR_SIZE-1:0] i_waddr,
    input  logic [RAM_WIDTH-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_SIZE-1:0] i_raddr,
    output logic [RAM_WIDTH-1:0] o_rdata
);
    localparam int DEPTH = 2 ** ADDR_SIZE;

    logic [RAM_WIDTH-1:0] r_mem [DEPTH];
    logic [RAM_WIDTH-1:0] r_rdata;

    // Storage write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; same-edge write is not visible here (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= {RAM_WIDTH{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= {RAM_WIDTH{1'b0}};
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/ram_dp_responder.sv
// ram_dp_responder: dual-port RAM acting as the DUV end of the RAM interface.
// After reset an INIT sequence zeroes every word (busy=1); strobes seen then
// are dropped and flagged in the sticky drop_err. In READY one write and one
// read are accepted per clock with one cycle of read latency.
// Optional build macro RAM_BYPASS_EN: same-address read+write returns the new
// write data (write-first); without it the old contents are returned.
module ram_dp_responder #(
    parameter int RAM_WIDTH = ram_pkg::RAM_WIDTH,
    parameter int ADDR_SIZE = ram_pkg::ADDR_SIZE
) (
    input  logic                clk,
    input  logic                resetn,
    ram_dp_responder_if.slave   ram_if
);
    import ram_pkg::*;

    localparam logic [0:0]           ST_INIT   = INIT;
    localparam logic [0:0]           ST_READY  = READY;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = {ADDR_SIZE{1'b1}};
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    logic [0:0]           r_state;
    logic [ADDR_SIZE-1:0] r_clr_addr;
    logic                 r_busy;
    logic                 r_drop_err;
    logic                 r_rd_valid;

    logic                 w_we;
    logic [ADDR_SIZE-1:0] w_waddr;
    logic [RAM_WIDTH-1:0] w_wdata;
    logic                 w_re;
    logic [RAM_WIDTH-1:0] w_rdata;
    logic [RAM_WIDTH-1:0] w_data_out;
    logic                 w_strobe;

    assign w_strobe = ram_if.write | ram_if.read;

    // Clear sequencer: walk every address in INIT, then settle in READY.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_INIT;
            r_clr_addr <= {ADDR_SIZE{1'b0}};
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_addr <= r_clr_addr + ADDR_ONE;
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_INIT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_READY: begin
                    r_state    <= ST_READY;
                    r_clr_addr <= r_clr_addr;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_clr_addr <= {ADDR_SIZE{1'b0}};
                    r_busy     <= 1'b1;
                end
            endcase
        end
    end

    // Sticky flag: any strobe during INIT is dropped and remembered until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drop_err <= 1'b0;
        end else if ((r_state == ST_INIT) && w_strobe) begin
            r_drop_err <= 1'b1;
        end else begin
            r_drop_err <= r_drop_err;
        end
    end

    // Read-valid tracks an accepted read one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_valid <= 1'b0;
        end else if ((r_state == ST_READY) && ram_if.read) begin
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    // Port steering: INIT owns the write port, READY hands it to the bus.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = {ADDR_SIZE{1'b0}};
        w_wdata = {RAM_WIDTH{1'b0}};
        w_re    = 1'b0;
        if (r_state == ST_INIT) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = {RAM_WIDTH{1'b0}};
            w_re    = 1'b0;
        end else begin
            w_we    = ram_if.write;
            w_waddr = ram_if.wr_address;
            w_wdata = ram_if.data_in;
            w_re    = ram_if.read;
        end
    end

    ram_dp_array #(
        .RAM_WIDTH (RAM_WIDTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk     (clk),
        .rst_n   (resetn),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (ram_if.rd_address),
        .o_rdata (w_rdata)
    );

`ifdef RAM_BYPASS_EN
    logic                 r_byp_hit;
    logic [RAM_WIDTH-1:0] r_byp_data;

    // Capture write data when a same-address read/write collides in READY.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= {RAM_WIDTH{1'b0}};
        end else if ((r_state == ST_READY) && ram_if.read && ram_if.write &&
                     (ram_if.rd_address == ram_if.wr_address)) begin
            r_byp_hit  <= 1'b1;
            r_byp_data <= ram_if.data_in;
        end else begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= {RAM_WIDTH{1'b0}};
        end
    end

    assign w_data_out = r_byp_hit ? r_byp_data : w_rdata;
`else
    assign w_data_out = w_rdata;
`endif

    assign ram_if.data_out = w_data_out;
    assign ram_if.rd_valid = r_rd_valid;
    assign ram_if.busy     = r_busy;
    assign ram_if.drop_err = r_drop_err;
endmodule
